// File: rtl/pipeline_hazard_ctrl_if.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
// Data-memory request/ready handshake between the hazard controller and the
// data memory.
//   dmem_req   : controller -> memory, an access is being requested this cycle
//   dmem_ready : memory -> controller, the requested access completes this cycle
// Handshake: an access completes on the first rising clock edge at which
// dmem_req and dmem_ready are both high. dmem_req stays high, and the
// request stays unchanged, until that edge. dmem_ready has no meaning
// while dmem_req is low.
// Modports: master = controller side, slave = memory side.
// ----------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if;
    logic dmem_req;
    logic dmem_ready;

    modport master (output dmem_req, input dmem_ready);
    modport slave  (input dmem_req, output dmem_ready);
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Central sequencer for a 5-stage pipeline. It generates the write-enable,
// flush and hold controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It handles
// three cases: taken branches resolved in MEM, load-use hazards detected in ID,
// and multi-cycle data-memory accesses. A watchdog catches memory accesses
// that never complete.
//
// Optional feature: define PERF_CNT_EN to add the stall_cnt and flush_cnt
// performance counters.
//
// Ports
//   clk, rst_n         clock (rising edge), synchronous active-low reset
//   id_rs1/id_rs2      source registers of the instruction in ID
//   id_use_rs1/2       the ID instruction really reads rs1/rs2
//   idex_rd            destination register of the instruction in EX
//   idex_MemRead       the instruction in EX is a load
//   exmem_Branch       the instruction in MEM is a conditional branch
//   exmem_zero_flag    ALU zero result of the instruction in MEM
//   exmem_funct3       funct3 of the instruction in MEM (BEQ=000, BNE=001)
//   exmem_MemRead/Write the instruction in MEM is a load/store
//   dmem               data-memory handshake (dmem_req out, dmem_ready in)
//   pc_write, pc_sel_branch, ifid_write, ifid_flush, idex_write, idex_flush,
//   exmem_hold, exmem_flush, memwb_bubble   pipeline controls
//   mem_timeout        sticky watchdog error flag
//   state_dbg          current FSM state (0=RUN, 1=WAIT, 2=ERR)
//   stall_cnt, flush_cnt  performance counters (PERF_CNT_EN only)
// ----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int TMO_W       = 8,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4:0]           id_rs1,
    input  logic [4:0]           id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic [4:0]           idex_rd,
    input  logic                 idex_MemRead,
    input  logic                 exmem_Branch,
    input  logic                 exmem_zero_flag,
    input  logic [2:0]           exmem_funct3,
    input  logic                 exmem_MemRead,
    input  logic                 exmem_MemWrite,
    pipeline_hazard_ctrl_if.master dmem,
    output logic                 pc_write,
    output logic                 pc_sel_branch,
    output logic                 ifid_write,
    output logic                 ifid_flush,
    output logic                 idex_write,
    output logic                 idex_flush,
    output logic                 exmem_hold,
    output logic                 exmem_flush,
    output logic                 memwb_bubble,
    output logic                 mem_timeout,
`ifdef PERF_CNT_EN
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt,
`endif
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_WAIT = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [TMO_W-1:0] wait_cnt, wait_cnt_nx;
    logic             tmo_q, tmo_nx;

    logic taken, memop, lu;
    logic unused_funct3;

    // Only funct3[0] tells BEQ from BNE; the other bits do not matter here.
    assign unused_funct3 = ^exmem_funct3[2:1];

    assign taken = exmem_Branch & (exmem_zero_flag ^ exmem_funct3[0]);
    assign memop = exmem_MemRead | exmem_MemWrite;
    assign lu    = idex_MemRead && (idex_rd != 5'd0) &&
                   ((id_use_rs1 && (id_rs1 == idex_rd)) ||
                    (id_use_rs2 && (id_rs2 == idex_rd)));

    assign state_dbg   = state;
    // The flag register still holds its old value during the reset cycle.
    // Gate the output so it reads 0 for the whole time reset is held.
    assign mem_timeout = tmo_q & rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_RUN;
            wait_cnt <= '0;
            tmo_q    <= 1'b0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
            tmo_q    <= tmo_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        wait_cnt_nx   = wait_cnt;
        tmo_nx        = tmo_q;
        dmem.dmem_req = 1'b0;
        pc_write      = 1'b1;
        pc_sel_branch = 1'b0;
        ifid_write    = 1'b1;
        ifid_flush    = 1'b0;
        idex_write    = 1'b1;
        idex_flush    = 1'b0;
        exmem_hold    = 1'b0;
        exmem_flush   = 1'b0;
        memwb_bubble  = 1'b0;

        case (state)
            S_RUN: begin
                dmem.dmem_req = memop;
                if (taken) begin
                    pc_sel_branch = 1'b1;
                    ifid_flush    = 1'b1;
                    idex_flush    = 1'b1;
                    exmem_flush   = 1'b1;
                end else if (memop && !dmem.dmem_ready) begin
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    idex_write   = 1'b0;
                    exmem_hold   = 1'b1;
                    memwb_bubble = 1'b1;
                    state_nx     = S_WAIT;
                    wait_cnt_nx  = TMO_W'(1);
                end else if (lu) begin
                    // A bubble goes into EX. EX/MEM keeps advancing.
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                end
            end
            S_WAIT: begin
                dmem.dmem_req = 1'b1;
                if (dmem.dmem_ready) begin
                    // Release cycle uses plain RUN controls. Any load-use is
                    // handled in RUN on the next cycle.
                    state_nx    = S_RUN;
                    wait_cnt_nx = '0;
                end else begin
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    idex_write   = 1'b0;
                    exmem_hold   = 1'b1;
                    memwb_bubble = 1'b1;
                    if (wait_cnt == TMO_W'(MEM_TIMEOUT)) begin
                        state_nx = S_ERR;
                        tmo_nx   = 1'b1;
                    end else begin
                        wait_cnt_nx = wait_cnt + 1'b1;
                    end
                end
            end
            S_ERR: begin
                pc_write     = 1'b0;
                ifid_write   = 1'b0;
                idex_write   = 1'b0;
                ifid_flush   = 1'b1;
                idex_flush   = 1'b1;
                exmem_flush  = 1'b1;
                memwb_bubble = 1'b1;
            end
            default: state_nx = S_RUN;
        endcase

        // While reset is held, outputs show the reset controls whatever the
        // state register contains.
        if (!rst_n) begin
            dmem.dmem_req = 1'b0;
            pc_write      = 1'b0;
            pc_sel_branch = 1'b0;
            ifid_write    = 1'b0;
            ifid_flush    = 1'b1;
            idex_write    = 1'b0;
            idex_flush    = 1'b1;
            exmem_hold    = 1'b0;
            exmem_flush   = 1'b1;
            memwb_bubble  = 1'b1;
        end
    end

`ifdef PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (state != S_ERR && !pc_write && stall_cnt != {CNT_W{1'b1}})
                stall_cnt <= stall_cnt + 1'b1;
            // pc_sel_branch is high only in RUN cycles where the branch is taken.
            if (pc_sel_branch && flush_cnt != {CNT_W{1'b1}})
                flush_cnt <= flush_cnt + 1'b1;
        end
    end
`endif

endmodule
